// File: rtl/rotate_arb_ctrl.sv
// Two-requester rotate unit: one shared 32-bit rotator behind a round-robin or
// fixed-priority grant, with a single-entry result register and a drain counter.
module rotate_arb_ctrl #(
    parameter int unsigned RR_EN = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [4:0]       req0_amt,
    input  logic             req0_dir,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [4:0]       req1_amt,
    input  logic             req1_dir,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        data_q, data_d;
    logic               id_q, id_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               can_accept;
    logic               any_valid;
    logic               accept;
    logic               drain;
    logic               gnt_id;

    logic [31:0]        op_data;
    logic [4:0]         op_amt;
    logic               op_dir;
    logic [5:0]         inv_amt;
    logic [31:0]        rot_l;
    logic [31:0]        rot_r;
    logic [31:0]        rot_res;

    // Grant selection: a tie goes to whoever did not win last under round-robin.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        can_accept = !rst && ((state_q == EMPTY) || rsp_ready);
        if (req0_valid && req1_valid) begin
            gnt_id = (RR_EN != 0) ? ~last_q : 1'b0;
        end else begin
            gnt_id = req1_valid;
        end
        accept     = can_accept & any_valid;
        drain      = (state_q == FULL) & rsp_ready;
        req0_ready = accept & ~gnt_id;
        req1_ready = accept &  gnt_id;
    end

    // Single shared rotator fed by the grant mux.
    always_comb begin
        op_data = gnt_id ? req1_data : req0_data;
        op_amt  = gnt_id ? req1_amt  : req0_amt;
        op_dir  = gnt_id ? req1_dir  : req0_dir;
        inv_amt = 6'd32 - {1'b0, op_amt};
        // A shift by 32 yields zero, so amt = 0 leaves the operand intact.
        rot_l   = (op_data << op_amt) | (op_data >> inv_amt);
        rot_r   = (op_data >> op_amt) | (op_data << inv_amt);
        rot_res = op_dir ? rot_l : rot_r;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = FULL;
            data_d  = rot_res;
            id_d    = gnt_id;
            last_d  = gnt_id;
        end else if (drain) begin
            state_d = EMPTY;
        end
        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;
    assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_rotate_arb_ctrl.sv
// Scoreboard bench: directed ops push hand-computed results into a queue,
// per-DUT monitors pop and compare on every response drain.
module tb_rotate_arb_ctrl;

    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [31:0] d;
        logic        id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t qa[$];
    exp_t qb[$];

    // DUT A: round-robin
    logic             a_r0v = 0, a_r1v = 0, a_r0dir = 0, a_r1dir = 0;
    logic [31:0]      a_r0d = '0, a_r1d = '0;
    logic [4:0]       a_r0a = '0, a_r1a = '0;
    logic             a_r0rdy, a_r1rdy, a_rsp_valid, a_rsp_id;
    logic             a_rsp_ready = 0;
    logic [31:0]      a_rsp_data;
    logic [CNT_W-1:0] a_cnt;

    // DUT B: fixed priority
    logic             b_r0v = 0, b_r1v = 0, b_r0dir = 0, b_r1dir = 0;
    logic [31:0]      b_r0d = '0, b_r1d = '0;
    logic [4:0]       b_r0a = '0, b_r1a = '0;
    logic             b_r0rdy, b_r1rdy, b_rsp_valid, b_rsp_id;
    logic             b_rsp_ready = 0;
    logic [31:0]      b_rsp_data;
    logic [CNT_W-1:0] b_cnt;

    rotate_arb_ctrl #(.RR_EN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(a_r0v), .req0_ready(a_r0rdy), .req0_data(a_r0d),
        .req0_amt(a_r0a), .req0_dir(a_r0dir),
        .req1_valid(a_r1v), .req1_ready(a_r1rdy), .req1_data(a_r1d),
        .req1_amt(a_r1a), .req1_dir(a_r1dir),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_data(a_rsp_data), .rsp_id(a_rsp_id), .done_cnt(a_cnt)
    );

    rotate_arb_ctrl #(.RR_EN(0), .CNT_W(CNT_W)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(b_r0v), .req0_ready(b_r0rdy), .req0_data(b_r0d),
        .req0_amt(b_r0a), .req0_dir(b_r0dir),
        .req1_valid(b_r1v), .req1_ready(b_r1rdy), .req1_data(b_r1d),
        .req1_amt(b_r1a), .req1_dir(b_r1dir),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_data(b_rsp_data), .rsp_id(b_rsp_id), .done_cnt(b_cnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] d, input logic id);
        exp_t e;
        e.d  = d;
        e.id = id;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] d, input logic id);
        exp_t e;
        e.d  = d;
        e.id = id;
        qb.push_back(e);
    endtask

    // Called at a negedge; presents one op on requester r of DUT A alone.
    task automatic run_vec(input logic r, input logic [31:0] d, input logic [4:0] amt,
                           input logic dir, input logic [31:0] exp_d);
        if (r == 1'b0) begin
            a_r0v = 1; a_r0d = d; a_r0a = amt; a_r0dir = dir;
            a_r1v = 0; a_r1d = $urandom; a_r1a = 5'($urandom); a_r1dir = 1'($urandom);
        end else begin
            a_r1v = 1; a_r1d = d; a_r1a = amt; a_r1dir = dir;
            a_r0v = 0; a_r0d = $urandom; a_r0a = 5'($urandom); a_r0dir = 1'($urandom);
        end
        push_a(exp_d, r);
        #1;
        check("vec_ready", r ? a_r1rdy : a_r0rdy, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        #2;
        if (!rst && a_rsp_valid && a_rsp_ready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_a_unexpected: got data %h id %0d expected no response", a_rsp_data, a_rsp_id);
            end else begin
                e = qa.pop_front();
                check("rsp_a_data", a_rsp_data, e.d);
                check("rsp_a_id", a_rsp_id, e.id);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        #2;
        if (!rst && b_rsp_valid && b_rsp_ready) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_b_unexpected: got data %h id %0d expected no response", b_rsp_data, b_rsp_id);
            end else begin
                e = qb.pop_front();
                check("rsp_b_data", b_rsp_data, e.d);
                check("rsp_b_id", b_rsp_id, e.id);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // Reset behaviour with both requesters asserting valid
        a_r0v = 1; a_r1v = 1; b_r0v = 1; b_r1v = 1;
        a_rsp_ready = 1; b_rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_r0_ready", a_r0rdy, 0);
        check("rst_r1_ready", a_r1rdy, 0);
        check("rst_fp_r0_ready", b_r0rdy, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_data", a_rsp_data, 0);
        check("rst_rsp_id", a_rsp_id, 0);
        check("rst_done_cnt", a_cnt, 0);
        @(negedge clk);
        rst = 0;
        a_r0v = 0; a_r1v = 0; b_r0v = 0; b_r1v = 0;
        a_rsp_ready = 0;
        b_rsp_ready = 0;
        @(negedge clk);

        // req0 left rotate, one-cycle latency
        run_vec(0, 32'h8000_0001, 5'd1, 1'b1, 32'h0000_0003);
        a_r0v = 0;
        a_rsp_ready = 1;
        #1;
        check("lat_rsp_valid", a_rsp_valid, 1);
        check("lat_rsp_data", a_rsp_data, 32'h0000_0003);
        check("lat_rsp_id", a_rsp_id, 0);
        @(negedge clk);
        #1;
        check("drain_empty", a_rsp_valid, 0);
        check("drain_cnt", a_cnt, 1);
        @(negedge clk);

        // Back-to-back single-requester vectors
        run_vec(1, 32'h0000_0001, 5'd4,  1'b0, 32'h1000_0000);
        run_vec(1, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF);
        run_vec(0, 32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678);
        run_vec(0, 32'h1234_5678, 5'd8,  1'b0, 32'h7812_3456);
        run_vec(1, 32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000);
        run_vec(0, 32'hABCD_1234, 5'd16, 1'b1, 32'h1234_ABCD);
        a_r0v = 0; a_r1v = 0;
        @(negedge clk);
        #1;
        check("b2b_cnt", a_cnt, 7);

        // Round-robin alternation from reset, one result per cycle
        @(negedge clk);
        do_reset();
        a_rsp_ready = 1;
        a_r0v = 1; a_r0d = 32'h0000_0010; a_r0a = 5'd4; a_r0dir = 1'b1;
        a_r1v = 1; a_r1d = 32'h0000_0010; a_r1a = 5'd4; a_r1dir = 1'b0;
        push_a(32'h0000_0100, 0);
        push_a(32'h0000_0001, 1);
        push_a(32'h0000_0100, 0);
        push_a(32'h0000_0001, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_r0_ready", a_r0rdy, ((i % 2) == 0) ? 1 : 0);
            check("rr_r1_ready", a_r1rdy, ((i % 2) == 1) ? 1 : 0);
            @(negedge clk);
        end
        a_r0v = 0; a_r1v = 0;
        @(negedge clk);
        #1;
        check("rr_done_cnt", a_cnt, 4);
        check("rr_empty", a_rsp_valid, 0);

        // Backpressure: result held, readies low, accept on rsp_ready rise
        @(negedge clk);
        a_rsp_ready = 0;
        run_vec(0, 32'hF000_0000, 5'd4, 1'b1, 32'h0000_000F);
        a_r0v = 0;
        a_r1v = 1; a_r1d = 32'h0000_FFFF; a_r1a = 5'd8; a_r1dir = 1'b0;
        push_a(32'hFF00_00FF, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_r0_ready", a_r0rdy, 0);
            check("bp_r1_ready", a_r1rdy, 0);
            check("bp_hold_data", a_rsp_data, 32'h0000_000F);
            check("bp_hold_valid", a_rsp_valid, 1);
            @(negedge clk);
        end
        a_rsp_ready = 1;
        #1;
        check("bp_release_ready", a_r1rdy, 1);
        @(negedge clk);
        a_r1v = 0;
        #1;
        check("bp_new_data", a_rsp_data, 32'hFF00_00FF);
        check("bp_new_id", a_rsp_id, 1);
        @(negedge clk);
        #1;
        check("bp_empty", a_rsp_valid, 0);

        // Reset while FULL discards the pending result
        @(negedge clk);
        a_rsp_ready = 0;
        a_r0v = 1; a_r0d = 32'h0000_0001; a_r0a = 5'd1; a_r0dir = 1'b1;
        @(negedge clk);
        a_r1v = 1;
        a_rsp_ready = 1;
        rst = 1;
        #1;
        check("rstfull_r0_ready", a_r0rdy, 0);
        check("rstfull_r1_ready", a_r1rdy, 0);
        @(negedge clk);
        #1;
        check("rstfull_valid", a_rsp_valid, 0);
        check("rstfull_cnt", a_cnt, 0);
        check("rstfull_data", a_rsp_data, 0);
        rst = 0;
        a_r0v = 0; a_r1v = 0;
        @(negedge clk);

        // done_cnt wraps 255 -> 0
        a_r0v = 1; a_r0d = 32'hA5A5_A5A5; a_r0a = 5'd0; a_r0dir = 1'b1;
        for (int i = 0; i < 255; i++) begin
            push_a(32'hA5A5_A5A5, 0);
            @(negedge clk);
        end
        a_r0v = 0;
        @(negedge clk);
        #1;
        check("wrap_cnt_255", a_cnt, 255);
        @(negedge clk);
        run_vec(0, 32'h0000_0F00, 5'd8, 1'b1, 32'h000F_0000);
        a_r0v = 0;
        @(negedge clk);
        #1;
        check("wrap_cnt_0", a_cnt, 0);

        // Fixed priority: req0 always wins, req1 only when alone
        @(negedge clk);
        b_rsp_ready = 1;
        b_r0v = 1; b_r0d = 32'h0000_0003; b_r0a = 5'd1; b_r0dir = 1'b1;
        b_r1v = 1; b_r1d = 32'h0000_0003; b_r1a = 5'd1; b_r1dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_b(32'h0000_0006, 0);
            #1;
            check("fp_r0_ready", b_r0rdy, 1);
            check("fp_r1_ready", b_r1rdy, 0);
            @(negedge clk);
        end
        b_r0v = 0;
        push_b(32'h8000_0001, 1);
        #1;
        check("fp_r1_alone", b_r1rdy, 1);
        @(negedge clk);
        b_r1v = 0;
        @(negedge clk);
        #1;
        check("fp_done_cnt", b_cnt, 5);

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
            @(negedge clk);
        end
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
